// File: rtl/sync_up_counter.sv
// sync_up_counter: synchronous modulo-MODULUS up counter that wraps from
// MODULUS-1 back to 0. It supports count enable, a parallel load, and a
// combinational terminal-count output for cascading. It also keeps a
// saturating wrap tally with a sticky overflow flag.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   en        in   count enable
//   load      in   parallel-load strobe (priority over en)
//   load_val  in   [WIDTH-1:0] value to load; values >= MODULUS are rejected
//   clr_ovf   in   synchronous clear of wrap_cnt and ovf
//   count_out out  [WIDTH-1:0] registered count
//   tc        out  terminal count: en & ~load & (count_out == MODULUS-1)
//   wrap_cnt  out  [WRAP_W-1:0] saturating number of wraps since reset/clear
//   ovf       out  sticky: a wrap happened while wrap_cnt was all-ones
//   load_err  out  one-cycle registered pulse for an out-of-range load
module sync_up_counter #(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned MODULUS = 4,
  parameter int unsigned WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  count_out,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              ovf,
  output logic              load_err
);

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  // One extra bit so that MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0]  count_q, count_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              ovf_q, ovf_d;
  logic              lerr_q, lerr_d;

  logic at_last;
  logic load_ok;
  logic wrap_evt;

  assign at_last  = (count_q == LAST);
  assign load_ok  = ({1'b0, load_val} < MOD_EXT);
  // A wrap happens only on a plain increment. A load never counts as a
  // wrap, even an invalid one, because en is ignored in that cycle.
  assign wrap_evt = en & ~load & at_last;

  always_comb begin
    count_d = count_q;
    lerr_d  = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         lerr_d  = 1'b1;
    end else if (en) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  always_comb begin
    wrap_d = wrap_q;
    ovf_d  = ovf_q;
    // The clear wins over a wrap in the same cycle, so that wrap is dropped.
    if (clr_ovf) begin
      wrap_d = '0;
      ovf_d  = 1'b0;
    end else if (wrap_evt) begin
      if (wrap_q == '1) ovf_d  = 1'b1;
      else              wrap_d = wrap_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= '0;
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count_out = count_q;
  assign tc        = wrap_evt;
  assign wrap_cnt  = wrap_q;
  assign ovf       = ovf_q;
  assign load_err  = lerr_q;

endmodule

// File: tb/tb_sync_up_counter.sv
// Bench for sync_up_counter. It drives two instances from the same inputs:
//   - u_dut4: the default configuration, MODULUS=4 and WRAP_W=8.
//   - u_dut3: a non-power-of-two modulus with a narrow tally, MODULUS=3 and WRAP_W=2.
// A behavioural model tracks, for each instance, the count and the total
// number of wraps since the last reset or clear. Expected outputs come from
// that model:
//   - wrap_cnt is min(total wraps, saturation value).
//   - ovf is (total wraps > saturation value).
module tb_sync_up_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, load, clr_ovf;
  logic [1:0] load_val;

  logic [1:0] c4, c3;
  logic       tc4, tc3, ovf4, ovf3, le4, le3;
  logic [7:0] w4;
  logic [1:0] w3;

  always #5 clk = ~clk;

  sync_up_counter #(.WIDTH(2), .MODULUS(4), .WRAP_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count_out(c4), .tc(tc4), .wrap_cnt(w4), .ovf(ovf4),
    .load_err(le4)
  );

  sync_up_counter #(.WIDTH(2), .MODULUS(3), .WRAP_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count_out(c3), .tc(tc3), .wrap_cnt(w3), .ovf(ovf3),
    .load_err(le3)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model; index 0 -> u_dut4, index 1 -> u_dut3.
  int unsigned mod_n[2] = '{4, 3};
  int unsigned sat_n[2] = '{255, 3};
  int unsigned m_cnt[2];
  int unsigned m_wraps[2];
  bit          m_lerr[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_wraps[i] = 0; m_lerr[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit wrapped = 0;
      m_lerr[i] = 0;
      if (load) begin
        if (int'(load_val) < int'(mod_n[i])) m_cnt[i] = load_val;
        else                                 m_lerr[i] = 1;
      end else if (en) begin
        wrapped  = (m_cnt[i] == mod_n[i] - 1);
        m_cnt[i] = (m_cnt[i] + 1) % mod_n[i];
      end
      if (clr_ovf)      m_wraps[i] = 0;
      else if (wrapped) m_wraps[i] = m_wraps[i] + 1;
    end
  endtask

  function automatic int unsigned exp_wrap(input int i);
    return (m_wraps[i] > sat_n[i]) ? sat_n[i] : m_wraps[i];
  endfunction

  function automatic bit exp_tc(input int i);
    return en && !load && (m_cnt[i] == mod_n[i] - 1);
  endfunction

  task automatic check_regs();
    check("m4.count",    c4,   m_cnt[0]);
    check("m4.wrap_cnt", w4,   exp_wrap(0));
    check("m4.ovf",      ovf4, m_wraps[0] > sat_n[0]);
    check("m4.load_err", le4,  m_lerr[0]);
    check("m3.count",    c3,   m_cnt[1]);
    check("m3.wrap_cnt", w3,   exp_wrap(1));
    check("m3.ovf",      ovf3, m_wraps[1] > sat_n[1]);
    check("m3.load_err", le3,  m_lerr[1]);
  endtask

  // One clock: drive inputs shortly after a rising edge, check tc mid-cycle,
  // then check the registered outputs 1 ns after the next rising edge.
  task automatic step(input logic e, input logic l, input logic [1:0] lv, input logic c);
    en = e; load = l; load_val = lv; clr_ovf = c;
    #3;
    check("m4.tc", tc4, exp_tc(0));
    check("m3.tc", tc3, exp_tc(1));
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  initial begin
    logic [1:0] seq4 [6];
    seq4 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    // Hold reset low for 200 ns with en high; nothing may move.
    reset = 1'b0; en = 1'b1; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
    model_reset();
    #100;
    check_regs();
    check("rst.tc4", tc4, 1'b0);
    #100;
    reset = 1'b1;

    // Count from the first edge after reset release: 1,2,3,0,1,2.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 2'd0, 1'b0);
      check("seq4", c4, seq4[k]);
      if (k == 3) check("first_wrap4", w4, 8'd1);
    end

    // A load takes priority over the increment.
    step(1'b1, 1'b1, 2'd1, 1'b0);
    step(1'b1, 1'b1, 2'd2, 1'b0);
    check("load_prio4", c4, 2'd2);
    // Loading 0 does not count as a wrap.
    step(1'b1, 1'b1, 2'd0, 1'b0);
    // Out-of-range load for MODULUS=3: the count holds and load_err pulses once.
    step(1'b1, 1'b1, 2'd3, 1'b0);
    check("bad_load3", le3, 1'b1);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("bad_load3_end", le3, 1'b0);

    // en gating from a count of 2: 1,0,0,1 gives 3,3,3,0 on the modulo-4 instance.
    step(1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    check("gate4", c4, 2'd0);

    // Free run long enough to saturate both wrap tallies and set ovf.
    for (int k = 0; k < 1100; k++) step(1'b1, 1'b0, 2'd0, 1'b0);
    check("sat4", w4, 8'hff);
    check("ovf3_sticky", ovf3, 1'b1);
    // Hold clr_ovf high across wraps; the clear wins every time.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 2'd0, 1'b1);
    check("clr_w3", w3, 2'd0);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
           2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0));
    end

    // Assert reset asynchronously mid-cycle at a count of 2; it must clear without a clock edge.
    step(1'b0, 1'b1, 2'd2, 1'b0);
    en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async.c4", c4, 2'd0);
    check("async.c3", c3, 2'd0);
    check("async.w4", w4, 8'd0);
    check("async.ovf3", ovf3, 1'b0);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_regs();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
